// File: rtl/mem_access_stage.sv
// mem_access_stage: M-stage of the MIPS pipeline. Issues data-memory
// requests, sign/zero-extends load data, flags misaligned accesses,
// stalls upstream while a request is outstanding, and registers the
// results toward writeback (acts as the M/W pipeline register).
module mem_access_stage #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int REG_W  = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic                  in_regwrite,
    input  logic                  in_memtoreg,
    input  logic                  in_memwrite,
    input  logic [1:0]            in_size,
    input  logic                  in_unsigned,
    input  logic [ADDR_W-1:0]     in_aluout,
    input  logic [DATA_W-1:0]     in_writedata,
    input  logic [REG_W-1:0]      in_writereg,
    output logic                  stall,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W/8-1:0]   mem_be,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic                  mem_ack,
    input  logic [DATA_W-1:0]     mem_rdata,
    output logic                  out_valid,
    output logic                  out_regwrite,
    output logic                  out_memtoreg,
    output logic [DATA_W-1:0]     out_aluout,
    output logic [DATA_W-1:0]     out_readdata,
    output logic [REG_W-1:0]      out_writereg,
    output logic                  out_misalign
);

    localparam int NB = DATA_W / 8;
    localparam int LB = $clog2(NB);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] REQ  = 1'b1;

    logic [0:0]        state;

    // Latched memory op, held stable for the whole request
    logic              r_regwrite;
    logic              r_memtoreg;
    logic              r_memwrite;
    logic              r_unsigned;
    logic [1:0]        r_size;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [REG_W-1:0]  r_writereg;

    logic              is_mem;
    logic              aligned;
    logic              start_req;
    logic              misalign_op;
    logic              req_active;

    logic [LB-1:0]     lane;
    logic [DATA_W-1:0] shifted;
    logic [DATA_W-1:0] field_mask;
    logic              sign;
    logic [DATA_W-1:0] load_ext;

    // Classify the incoming op and derive the stall / request qualifiers
    always_comb begin
        is_mem = in_valid & (in_memtoreg | in_memwrite);
        case (in_size)
            2'b00:   aligned = 1'b1;
            2'b01:   aligned = ~in_aluout[0];
            2'b10:   aligned = (in_aluout[1:0] == 2'b00);
            default: aligned = (DATA_W == 64) && (in_aluout[2:0] == 3'b000);
        endcase
        start_req   = (state == IDLE) && is_mem && aligned;
        misalign_op = is_mem && !aligned;
        // Reset wins over everything, including an ack in the same cycle
        req_active  = (state == REQ) && !reset;
        stall       = !reset && (start_req || (req_active && !mem_ack));
    end

    // Memory port: byte enables and lane-replicated store data from the latched op
    always_comb begin
        lane      = r_addr[LB-1:0];
        mem_req   = req_active;
        mem_we    = req_active & r_memwrite;
        mem_addr  = r_addr;
        mem_be    = '0;
        if (req_active) begin
            case (r_size)
                2'b00:   mem_be = NB'(1)  << lane;
                2'b01:   mem_be = NB'(3)  << lane;
                2'b10:   mem_be = NB'(15) << lane;
                default: mem_be = '1;
            endcase
        end
        case (r_size)
            2'b00:   mem_wdata = {NB{r_wdata[7:0]}};
            2'b01:   mem_wdata = {(NB/2){r_wdata[15:0]}};
            2'b10:   mem_wdata = {(NB/4){r_wdata[31:0]}};
            default: mem_wdata = r_wdata;
        endcase
    end

    // Load path: shift the addressed lane down, then mask and extend
    always_comb begin
        shifted = mem_rdata >> {lane, 3'b000};
        case (r_size)
            2'b00: begin
                field_mask = DATA_W'(8'hFF);
                sign       = shifted[7];
            end
            2'b01: begin
                field_mask = DATA_W'(16'hFFFF);
                sign       = shifted[15];
            end
            2'b10: begin
                field_mask = DATA_W'(32'hFFFF_FFFF);
                sign       = shifted[31];
            end
            default: begin
                field_mask = '1;
                sign       = shifted[DATA_W-1];
            end
        endcase
        load_ext = (shifted & field_mask) |
                   (~field_mask & {DATA_W{sign & ~r_unsigned}});
    end

    // Request register: capture the op when a request is launched
    always_ff @(posedge clk) begin
        if (reset) begin
            r_regwrite <= 1'b0;
            r_memtoreg <= 1'b0;
            r_memwrite <= 1'b0;
            r_unsigned <= 1'b0;
            r_size     <= 2'b00;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_writereg <= '0;
        end else if (start_req) begin
            r_regwrite <= in_regwrite;
            r_memtoreg <= in_memtoreg;
            r_memwrite <= in_memwrite;
            r_unsigned <= in_unsigned;
            r_size     <= in_size;
            r_addr     <= in_aluout;
            r_wdata    <= in_writedata;
            r_writereg <= in_writereg;
        end
    end

    // FSM: IDLE launches aligned memory ops, REQ waits for the ack
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    if (start_req) state <= REQ;
                REQ:     if (mem_ack) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // M/W output register: loads on a completed op, otherwise a bubble that holds the data
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid    <= 1'b0;
            out_regwrite <= 1'b0;
            out_memtoreg <= 1'b0;
            out_aluout   <= '0;
            out_readdata <= '0;
            out_writereg <= '0;
            out_misalign <= 1'b0;
        end else begin
            out_valid    <= 1'b0;
            out_misalign <= 1'b0;
            if (state == IDLE && in_valid && !start_req) begin
                out_valid    <= 1'b1;
                out_regwrite <= in_regwrite & ~misalign_op;
                out_memtoreg <= in_memtoreg;
                out_aluout   <= DATA_W'(in_aluout);
                out_readdata <= '0;
                out_writereg <= in_writereg;
                out_misalign <= misalign_op;
            end else if (state == REQ && mem_ack) begin
                out_valid    <= 1'b1;
                out_regwrite <= r_regwrite;
                out_memtoreg <= r_memtoreg;
                out_aluout   <= DATA_W'(r_addr);
                out_readdata <= r_memtoreg ? load_ext : '0;
                out_writereg <= r_writereg;
            end
        end
    end

endmodule
